// File: rtl/line_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : line_data_memory
// Description : Line-granular backing memory with fixed access latency,
//               serving cache line fills and write-backs.
// Revision    : 1.0 - initial release
// ============================================================================
module line_data_memory #(
    parameter int MEM_DEPTH  = 16384,
    parameter int BLOCK_SIZE = 16,
    parameter int DELAY      = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    mem_ready,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout
);

    localparam int c_LW = BLOCK_SIZE * 8;
    localparam int c_AW = $clog2(MEM_DEPTH);
    localparam int c_CW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(DELAY - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CW-1:0]    r_count;
    logic               r_op_wr;
    logic [c_AW-1:0]    r_idx;
    logic [c_LW-1:0]    r_din;
    logic [c_LW-1:0]    r_dout;
    logic [c_LW-1:0]    r_mem [MEM_DEPTH];

    logic               w_ready;
    logic               w_accept;
    logic               w_done;
    logic               w_mem_we;
    logic               w_unused_addr;

    assign w_ready       = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign w_accept      = is_input_valid && w_ready && (mem_read || mem_write);
    assign w_done        = (r_state == ST_BUSY) && (r_count == '0);
    assign w_mem_we      = w_done && r_op_wr;
    assign w_unused_addr = &{1'b0, addr[31:c_AW]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_done)   w_state_nxt = r_op_wr ? ST_IDLE : ST_RESP;
            ST_RESP: w_state_nxt = w_accept ? ST_BUSY : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request is captured at accept so the requester may move on immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_din   <= '0;
            r_dout  <= '0;
        end else begin
            if (w_accept) begin
                r_op_wr <= mem_write;
                r_idx   <= addr[c_AW-1:0];
                r_din   <= din;
                r_count <= c_CNT_LOAD;
            end else if ((r_state == ST_BUSY) && (r_count != '0)) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_done && !r_op_wr) begin
                r_dout <= r_mem[r_idx];
            end
        end
    end

    // Storage is deliberately outside reset; an aborted write never reaches it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_din;
        end
    end

    assign mem_ready       = w_ready;
    assign is_output_valid = (r_state == ST_RESP);
    assign dout            = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_line_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_data_memory
// Description : Scoreboard bench for line_data_memory with DELAY = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_data_memory;

    localparam int c_DELAY = 4;
    localparam int c_LW    = 128;

    logic            clk;
    logic            reset;
    logic            is_input_valid;
    logic [31:0]     addr;
    logic            mem_read;
    logic            mem_write;
    logic [c_LW-1:0] din;
    logic            mem_ready;
    logic            is_output_valid;
    logic [c_LW-1:0] dout;

    int n_pass  = 0;
    int n_total = 0;
    logic [c_LW-1:0] exp_q [$];

    localparam logic [c_LW-1:0] c_V1   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [c_LW-1:0] c_V2   = 128'h11112222_33334444_55556666_77778888;
    localparam logic [c_LW-1:0] c_JUNK = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

    line_data_memory #(
        .MEM_DEPTH  (16384),
        .BLOCK_SIZE (16),
        .DELAY      (c_DELAY)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .mem_ready       (mem_ready),
        .is_output_valid (is_output_valid),
        .dout            (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [c_LW-1:0] act, input logic [c_LW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every qualified read response is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset && is_output_valid && mem_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_unexpected: got dout %h expected no response", dout);
            end else begin
                automatic logic [c_LW-1:0] e = exp_q.pop_front();
                if (dout === e) n_pass++;
                else $display("FAIL rd_data: got %h expected %h", dout, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at accept-edge+1.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [c_LW-1:0] d, input logic [c_LW-1:0] exp);
        int t = 0;
        while (!mem_ready && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) chk("issue_timeout", 128'(mem_ready), 128'd1);
        is_input_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        din       = d;
        if (rd && !wr) exp_q.push_back(exp);
        step();
        is_input_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Checks the BUSY window and arrival at the completion edge.
    task automatic expect_busy(input string name, input bit is_rd);
        for (int i = 0; i < c_DELAY; i++) begin
            chk({name, "_busy_ready"}, 128'(mem_ready), 128'd0);
            chk({name, "_busy_valid"}, 128'(is_output_valid), 128'd0);
            step();
        end
        chk({name, "_done_ready"}, 128'(mem_ready), 128'd1);
        chk({name, "_done_valid"}, 128'(is_output_valid), 128'(is_rd));
    endtask

    task automatic do_write(input string name, input logic [31:0] a, input logic [c_LW-1:0] d);
        issue(1'b0, 1'b1, a, d, '0);
        expect_busy(name, 1'b0);
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input logic [c_LW-1:0] e);
        issue(1'b1, 1'b0, a, '0, e);
        expect_busy(name, 1'b1);
        step();
        chk({name, "_after_valid"}, 128'(is_output_valid), 128'd0);
    endtask

    initial begin
        reset = 1'b0;
        is_input_valid = 1'b0;
        addr = '0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        din = '0;

        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_ready", 128'(mem_ready), 128'd1);
            chk("rst_valid", 128'(is_output_valid), 128'd0);
            chk("rst_dout", dout, '0);
        end
        reset = 1'b1;
        step();
        chk("post_rst_ready", 128'(mem_ready), 128'd1);
        chk("post_rst_valid", 128'(is_output_valid), 128'd0);
        chk("post_rst_dout", dout, '0);

        do_write("wr12", 32'h12, c_V1);
        do_read("rd12", 32'h12, c_V1);
        repeat (10) step();
        chk("dout_hold", dout, c_V1);

        // Back-to-back: read of 0x13 presented in RESP, inputs disturbed while BUSY.
        do_write("wr13", 32'h13, 128'h5);
        issue(1'b1, 1'b0, 32'h12, '0, c_V1);
        expect_busy("rd12b", 1'b1);
        issue(1'b1, 1'b0, 32'h13, '0, 128'h5);
        chk("b2b_accepted", 128'(mem_ready), 128'd0);
        is_input_valid = 1'b1;
        mem_write = 1'b1;
        addr = 32'h12;
        din = c_JUNK;
        step();
        step();
        is_input_valid = 1'b0;
        mem_write = 1'b0;
        addr = 32'h55;
        din = '1;
        for (int i = 2; i < c_DELAY; i++) step();
        chk("b2b_done_valid", 128'(is_output_valid), 128'd1);
        step();
        chk("b2b_after_valid", 128'(is_output_valid), 128'd0);
        do_read("rd12_nojunk", 32'h12, c_V1);

        // Upper address bits ignored; both strobes high means write.
        do_write("wr_alias", 32'hFFFF_0012, c_V2);
        do_read("rd_alias", 32'h12, c_V2);
        issue(1'b1, 1'b1, 32'h13, 128'h77, '0);
        expect_busy("wr_both", 1'b0);
        do_read("rd_both", 32'h13, 128'h77);

        // Reset aborts an in-flight write.
        do_write("wr20", 32'h20, 128'h1);
        issue(1'b0, 1'b1, 32'h20, 128'h2, '0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("abort_ready", 128'(mem_ready), 128'd1);
        chk("abort_valid", 128'(is_output_valid), 128'd0);
        chk("abort_dout", dout, '0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < c_DELAY + 2; i++) begin
            chk("abort_idle_ready", 128'(mem_ready), 128'd1);
            step();
        end
        do_read("rd20", 32'h20, 128'h1);

        repeat (3) step();
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
